bus_terminal_fifo: RTL and testbench

BUS_TERMINAL_FIFO -- requirements
Module: bus_terminal_fifo

---
 rtl/bus_terminal_fifo_pkg.sv | 35 +++
 rtl/bus_terminal_fifo_if.sv | 40 ++++
 rtl/bus_terminal_fifo_sync_fifo_fwft.sv | 88 ++++++++
 rtl/bus_terminal_fifo.sv | 96 +++++++++
 tb/tb_bus_terminal_fifo.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_terminal_fifo_pkg.sv
// Shared constants, counter types and packet helpers for the bus terminal FIFO.
// Imported by the interface, the FIFO primitive and the top level.
package bus_term_pkg;

  localparam int ID_W      = 8;
  localparam int CNT_W     = 16;
  localparam int MAX_PKT_W = 64;

  localparam logic [ID_W-1:0] BCAST_ID_DEF = 8'hFF;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t tx_drop;
    cnt_t rx_drop;
    cnt_t misroute;
  } evt_cnt_t;

  // Destination id sits in the top ID_W bits of a pkt_w-wide packet.
  function automatic logic [ID_W-1:0] get_id(input logic [MAX_PKT_W-1:0] pkt,
                                             input int unsigned pkt_w);
    logic [MAX_PKT_W-1:0] shifted;
    shifted = pkt >> (pkt_w - ID_W);
    return shifted[ID_W-1:0];
  endfunction

  function automatic cnt_t sat_inc(input cnt_t c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/bus_terminal_fifo_if.sv
// Agent/bus handshake bundle for one bus terminal.
// slave is the terminal's view, master is the driving environment's view.
interface bus_terminal_fifo_if #(
  parameter int PCKG_SZ = 16,
  parameter int DEPTH   = 8
);
  import bus_term_pkg::*;

  localparam int LVL_W = $clog2(DEPTH + 1);

  logic               wr_en;
  logic [PCKG_SZ-1:0] wr_data;
  logic               pndng;
  logic [PCKG_SZ-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [PCKG_SZ-1:0] D_push;
  logic               rd_en;
  logic [PCKG_SZ-1:0] rd_data;
  logic               rd_valid;
  logic [LVL_W-1:0]   tx_level;
  logic [LVL_W-1:0]   rx_level;
  logic [CNT_W-1:0]   tx_drop_cnt;
  logic [CNT_W-1:0]   rx_drop_cnt;
  logic [CNT_W-1:0]   misroute_cnt;
  logic               pop_err;

  modport slave (
    input  wr_en, wr_data, pop, push, D_push, rd_en,
    output pndng, D_pop, rd_data, rd_valid, tx_level, rx_level,
           tx_drop_cnt, rx_drop_cnt, misroute_cnt, pop_err
  );

  modport master (
    output wr_en, wr_data, pop, push, D_push, rd_en,
    input  pndng, D_pop, rd_data, rd_valid, tx_level, rx_level,
           tx_drop_cnt, rx_drop_cnt, misroute_cnt, pop_err
  );

endinterface

// File: rtl/bus_terminal_fifo_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with arbitrary (non power-of-two) depth.
// A write into a full FIFO is accepted when a read retires the head on the same edge.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_rd,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_wr_acc,
  output logic                       o_rd_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_empty;
  logic             w_rd_do;
  logic             w_wr_do;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Read only takes effect on a non-empty FIFO; a retiring read frees the slot for a full-cycle write.
  always_comb begin
    w_empty = (r_count == '0);
    w_rd_do = i_rd & ~w_empty;
    w_wr_do = i_wr & ((r_count != FULL_LVL) | w_rd_do);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_do) begin
        r_wr_ptr <= ptr_nxt(r_wr_ptr);
      end
      if (w_rd_do) begin
        r_rd_ptr <= ptr_nxt(r_rd_ptr);
      end
      case ({w_wr_do, w_rd_do})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until the count says otherwise.
  always_ff @(posedge clk) begin
    if (w_wr_do) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Fall-through head, forced to zero while empty so reset clears it at once.
  always_comb begin
    if (w_empty) begin
      o_rdata = '0;
    end else begin
      o_rdata = r_mem[r_rd_ptr];
    end
    o_valid  = ~w_empty;
    o_level  = r_count;
    o_wr_acc = w_wr_do;
    o_rd_err = i_rd & w_empty;
  end

endmodule

// File: rtl/bus_terminal_fifo.sv
// Bus terminal: TX FIFO from agent to bus, RX FIFO from bus to agent,
// plus saturating drop/misroute counters and a sticky pop-on-empty flag.
module bus_terminal_fifo
  import bus_term_pkg::*;
#(
  parameter int              DRVRS    = 4,
  parameter int              PCKG_SZ  = 16,
  parameter int              DEPTH    = 8,
  parameter int              TERM_ID  = 0,
  parameter logic [ID_W-1:0] BCAST_ID = BCAST_ID_DEF
) (
  input  logic                clk,
  input  logic                rst,
  bus_terminal_fifo_if.slave  bus
);

  localparam logic [ID_W-1:0] MY_ID = ID_W'(TERM_ID);

  logic            w_tx_acc;
  logic            w_tx_rd_err;
  logic            w_rx_acc;
  logic            w_rx_rd_err;
  logic [ID_W-1:0] w_push_id;
  logic            w_misroute;
  logic            w_tx_drop;
  logic            w_rx_drop;
  evt_cnt_t        r_cnt;
  logic            r_pop_err;

  sync_fifo_fwft #(
    .WIDTH (PCKG_SZ),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_wr     (bus.wr_en),
    .i_wdata  (bus.wr_data),
    .i_rd     (bus.pop),
    .o_rdata  (bus.D_pop),
    .o_valid  (bus.pndng),
    .o_level  (bus.tx_level),
    .o_wr_acc (w_tx_acc),
    .o_rd_err (w_tx_rd_err)
  );

  sync_fifo_fwft #(
    .WIDTH (PCKG_SZ),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_wr     (bus.push),
    .i_wdata  (bus.D_push),
    .i_rd     (bus.rd_en),
    .o_rdata  (bus.rd_data),
    .o_valid  (bus.rd_valid),
    .o_level  (bus.rx_level),
    .o_wr_acc (w_rx_acc),
    .o_rd_err (w_rx_rd_err)
  );

  // Misroute is judged on every push, whether or not the RX FIFO had room.
  always_comb begin
    w_push_id  = get_id(MAX_PKT_W'(bus.D_push), PCKG_SZ);
    w_misroute = bus.push & (w_push_id != MY_ID) & (w_push_id != BCAST_ID);
    w_tx_drop  = bus.wr_en & ~w_tx_acc;
    w_rx_drop  = bus.push & ~w_rx_acc;
  end

  // Event counters and sticky pop error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pop_err <= 1'b0;
    end else begin
      if (w_tx_drop) begin
        r_cnt.tx_drop <= sat_inc(r_cnt.tx_drop);
      end
      if (w_rx_drop) begin
        r_cnt.rx_drop <= sat_inc(r_cnt.rx_drop);
      end
      if (w_misroute) begin
        r_cnt.misroute <= sat_inc(r_cnt.misroute);
      end
      if (w_tx_rd_err) begin
        r_pop_err <= 1'b1;
      end
    end
  end

  assign bus.tx_drop_cnt  = r_cnt.tx_drop;
  assign bus.rx_drop_cnt  = r_cnt.rx_drop;
  assign bus.misroute_cnt = r_cnt.misroute;
  assign bus.pop_err      = r_pop_err;

endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Directed vector bench for bus_terminal_fifo (PCKG_SZ=16, DEPTH=4, TERM_ID=2).
module tb_bus_terminal_fifo;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  bus_terminal_fifo_if #(.PCKG_SZ(16), .DEPTH(4)) bif ();

  bus_terminal_fifo #(
    .DRVRS   (4),
    .PCKG_SZ (16),
    .DEPTH   (4),
    .TERM_ID (2),
    .BCAST_ID(8'hFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] wd;
    logic        pop;
    logic        push;
    logic [15:0] dp;
    logic        rd;
    logic        e_pndng;
    logic [15:0] e_dpop;
    logic [2:0]  e_txl;
    logic        e_rv;
    logic [15:0] e_rd;
    logic [2:0]  e_rxl;
    logic [15:0] e_txd;
    logic [15:0] e_rxd;
    logic [15:0] e_mis;
    logic        e_perr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic [15:0] wd, input logic pop,
                              input logic push, input logic [15:0] dp, input logic rd,
                              input logic pn, input logic [15:0] dpop, input int txl,
                              input logic rv, input logic [15:0] rdd, input int rxl,
                              input int txd, input int rxd, input int mis, input logic perr);
    vec_t v;
    v.wr = wr; v.wd = wd; v.pop = pop; v.push = push; v.dp = dp; v.rd = rd;
    v.e_pndng = pn; v.e_dpop = dpop; v.e_txl = 3'(txl);
    v.e_rv = rv; v.e_rd = rdd; v.e_rxl = 3'(rxl);
    v.e_txd = 16'(txd); v.e_rxd = 16'(rxd); v.e_mis = 16'(mis); v.e_perr = perr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bif.wr_en = 1'b0; bif.wr_data = 16'h0000; bif.pop = 1'b0;
    bif.push = 1'b0; bif.D_push = 16'h0000; bif.rd_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pndng"},    32'(bif.pndng),        32'd0);
    chk({tag, ".D_pop"},    32'(bif.D_pop),        32'd0);
    chk({tag, ".tx_level"}, 32'(bif.tx_level),     32'd0);
    chk({tag, ".rd_valid"}, 32'(bif.rd_valid),     32'd0);
    chk({tag, ".rd_data"},  32'(bif.rd_data),      32'd0);
    chk({tag, ".rx_level"}, 32'(bif.rx_level),     32'd0);
    chk({tag, ".tx_drop"},  32'(bif.tx_drop_cnt),  32'd0);
    chk({tag, ".rx_drop"},  32'(bif.rx_drop_cnt),  32'd0);
    chk({tag, ".misroute"}, 32'(bif.misroute_cnt), 32'd0);
    chk({tag, ".pop_err"},  32'(bif.pop_err),      32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();

    //        wr   wd       pop  push dp        rd   pn   dpop     txl rv   rd       rxl txd rxd mis perr
    // TX: fill, overflow, full+pop, drain, pop on empty, write+pop on empty
    vecs.push_back(mk(1'b1, 16'h02A1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02A1, 1, 1'b0, 16'h0000, 0, 0, 0, 0, 1'b0));
    vecs.push_back(mk(1'b1, 16'h02A2, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02A1, 2, 1'b0, 16'h0000, 0, 0, 0, 0, 1'b0));
    vecs.push_back(mk(1'b1, 16'h02A3, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02A1, 3, 1'b0, 16'h0000, 0, 0, 0, 0, 1'b0));
    vecs.push_back(mk(1'b1, 16'h02A4, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02A1, 4, 1'b0, 16'h0000, 0, 0, 0, 0, 1'b0));
    vecs.push_back(mk(1'b1, 16'h02A5, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02A1, 4, 1'b0, 16'h0000, 0, 1, 0, 0, 1'b0));
    vecs.push_back(mk(1'b1, 16'h02A6, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02A2, 4, 1'b0, 16'h0000, 0, 1, 0, 0, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02A3, 3, 1'b0, 16'h0000, 0, 1, 0, 0, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02A4, 2, 1'b0, 16'h0000, 0, 1, 0, 0, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02A6, 1, 1'b0, 16'h0000, 0, 1, 0, 0, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 16'h0000, 0, 1, 0, 0, 1'b0));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 16'h0000, 0, 1, 0, 0, 1'b1));
    vecs.push_back(mk(1'b1, 16'h02B1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h02B1, 1, 1'b0, 16'h0000, 0, 1, 0, 0, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 16'h0000, 0, 1, 0, 0, 1'b1));
    // RX: own / broadcast / foreign ids, drain, read on empty
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0211, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h0211, 1, 1, 0, 0, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFF22, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h0211, 2, 1, 0, 0, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0333, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h0211, 3, 1, 0, 1, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 16'hFF22, 2, 1, 0, 1, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 16'h0333, 1, 1, 0, 1, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 16'h0000, 0, 1, 0, 1, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 16'h0000, 0, 1, 0, 1, 1'b1));
    // RX: six pushes into empty FIFO, then full+push+rd, full+foreign push
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0201, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h0201, 1, 1, 0, 1, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0202, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h0201, 2, 1, 0, 1, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0203, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h0201, 3, 1, 0, 1, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0204, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h0201, 4, 1, 0, 1, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0205, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h0201, 4, 1, 1, 1, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0206, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h0201, 4, 1, 2, 1, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0107, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 16'h0202, 4, 1, 2, 2, 1'b1));
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0508, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 16'h0202, 4, 1, 3, 3, 1'b1));
    vecs.push_back(mk(1'b1, 16'h02C1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h02C1, 1, 1'b1, 16'h0203, 3, 1, 3, 3, 1'b1));

    // Reset state while rst is held
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bif.wr_en = vecs[i].wr;   bif.wr_data = vecs[i].wd; bif.pop   = vecs[i].pop;
      bif.push  = vecs[i].push; bif.D_push  = vecs[i].dp; bif.rd_en = vecs[i].rd;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.pndng", i),    32'(bif.pndng),        32'(vecs[i].e_pndng));
      chk($sformatf("v%0d.D_pop", i),    32'(bif.D_pop),        32'(vecs[i].e_dpop));
      chk($sformatf("v%0d.tx_level", i), 32'(bif.tx_level),     32'(vecs[i].e_txl));
      chk($sformatf("v%0d.rd_valid", i), 32'(bif.rd_valid),     32'(vecs[i].e_rv));
      chk($sformatf("v%0d.rd_data", i),  32'(bif.rd_data),      32'(vecs[i].e_rd));
      chk($sformatf("v%0d.rx_level", i), 32'(bif.rx_level),     32'(vecs[i].e_rxl));
      chk($sformatf("v%0d.tx_drop", i),  32'(bif.tx_drop_cnt),  32'(vecs[i].e_txd));
      chk($sformatf("v%0d.rx_drop", i),  32'(bif.rx_drop_cnt),  32'(vecs[i].e_rxd));
      chk($sformatf("v%0d.misroute", i), 32'(bif.misroute_cnt), 32'(vecs[i].e_mis));
      chk($sformatf("v%0d.pop_err", i),  32'(bif.pop_err),      32'(vecs[i].e_perr));
    end

    // Top both FIFOs up to full
    @(negedge clk);
    idle_inputs();
    bif.wr_en = 1'b1; bif.wr_data = 16'h02C2; bif.push = 1'b1; bif.D_push = 16'h0209;
    @(negedge clk);
    idle_inputs();
    bif.wr_en = 1'b1; bif.wr_data = 16'h02C3;
    @(negedge clk);
    bif.wr_data = 16'h02C4;
    @(posedge clk);
    #1;
    chk("fill.tx_level", 32'(bif.tx_level),     32'd4);
    chk("fill.rx_level", 32'(bif.rx_level),     32'd4);
    chk("fill.D_pop",    32'(bif.D_pop),        32'h02C1);
    chk("fill.rd_data",  32'(bif.rd_data),      32'h0203);
    chk("fill.misroute", 32'(bif.misroute_cnt), 32'd3);

    // Short reset pulse between clock edges
    idle_inputs();
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("postrst");

    // Inputs active across an edge while reset is held are ignored
    @(negedge clk);
    rst = 1'b1;
    bif.wr_en = 1'b1; bif.wr_data = 16'h02E1; bif.push = 1'b1; bif.D_push = 16'h0FE2;
    bif.pop = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("heldrst");
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    // First write after reset falls through
    @(negedge clk);
    bif.wr_en = 1'b1; bif.wr_data = 16'h02D1;
    @(posedge clk);
    #1;
    chk("after.pndng",    32'(bif.pndng),    32'd1);
    chk("after.D_pop",    32'(bif.D_pop),    32'h02D1);
    chk("after.tx_level", 32'(bif.tx_level), 32'd1);
    chk("after.pop_err",  32'(bif.pop_err),  32'd0);
    @(negedge clk);
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
